ddr3_line_adapter: RTL and testbench



---
 rtl/ddr3_pkg.sv | 27 ++
 rtl/ddr3_line_adapter.sv | 155 +++++++++++++++
 tb/tb_ddr3_line_adapter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_pkg.sv
// Shared constants for the DDR3 cache-line to MIG native-interface bridge.
// The adapter FSM state encoding is also exported on state_o for debug.
package ddr3_pkg;

    localparam int LINE_WIDTH      = 256;
    localparam int APP_DATA_WIDTH  = 128;
    localparam int LINE_ADDR_WIDTH = 29;
    localparam int APP_ADDR_WIDTH  = 28;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [3:0] {
        ST_CALIB    = 4'd0,
        ST_BOOT_ACK = 4'd1,
        ST_IDLE     = 4'd2,
        ST_WD0      = 4'd3,
        ST_WD1      = 4'd4,
        ST_WC0      = 4'd5,
        ST_WC1      = 4'd6,
        ST_RC0      = 4'd7,
        ST_RC1      = 4'd8,
        ST_RWAIT    = 4'd9,
        ST_ACK      = 4'd10
    } state_t;

endpackage

// File: rtl/ddr3_line_adapter.sv
// Splits each 256-bit cache-line transfer into two BL8 MIG commands (app addr +0/+8)
// and issues the one-shot boot acknowledge once MIG calibration completes.
module ddr3_line_adapter
    import ddr3_pkg::*;
#(
    parameter int LINE_W      = LINE_WIDTH,
    parameter int APP_DATA_W  = APP_DATA_WIDTH,
    parameter int LINE_ADDR_W = LINE_ADDR_WIDTH,
    parameter int APP_ADDR_W  = APP_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LINE_ADDR_W-1:0]  line_addr_i,
    input  logic [LINE_W-1:0]       line_data_i,
    output logic [LINE_W-1:0]       line_data_o,
    input  logic                    line_we_i,
    input  logic                    line_rd_i,
    output logic                    line_ack_o,
    output logic [APP_ADDR_W-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [APP_DATA_W-1:0]   app_wdf_data,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [APP_DATA_W/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_rdy,
    input  logic [APP_DATA_W-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid,
    input  logic                    init_calib_complete,
    output logic [3:0]              state_o
);

    state_t                 state;
    state_t                 next_state;
    logic [LINE_ADDR_W-6:0] base;
    logic [LINE_W-1:0]      wbuf;
    logic [1:0]             beats;
    logic                   capture;
    logic                   unused_addr_bits;

    // The line address is 32-byte aligned; the low bits carry no information.
    assign unused_addr_bits = ^line_addr_i[4:0];

    assign capture = app_rd_data_valid && (beats != 2'd2) &&
                     ((state == ST_RC0) || (state == ST_RC1) || (state == ST_RWAIT));

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CALIB;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CALIB:    if (init_calib_complete) next_state = ST_BOOT_ACK;
            ST_BOOT_ACK: next_state = ST_IDLE;
            ST_IDLE: begin
                if (line_we_i) begin
                    next_state = ST_WD0;
                end else if (line_rd_i) begin
                    next_state = ST_RC0;
                end
            end
            ST_WD0:      if (app_wdf_rdy) next_state = ST_WD1;
            ST_WD1:      if (app_wdf_rdy) next_state = ST_WC0;
            ST_WC0:      if (app_rdy) next_state = ST_WC1;
            ST_WC1:      if (app_rdy) next_state = ST_ACK;
            ST_RC0:      if (app_rdy) next_state = ST_RC1;
            ST_RC1:      if (app_rdy) next_state = ST_RWAIT;
            // A second beat landing in this very cycle also completes the line.
            ST_RWAIT:    if ((beats == 2'd2) || (capture && (beats == 2'd1))) next_state = ST_ACK;
            ST_ACK:      next_state = ST_IDLE;
            default:     next_state = ST_CALIB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base        <= '0;
            wbuf        <= '0;
            beats       <= 2'd0;
            line_data_o <= '0;
            line_ack_o  <= 1'b0;
        end else begin
            line_ack_o <= (next_state == ST_BOOT_ACK) || (next_state == ST_ACK);
            if ((state == ST_IDLE) && (line_we_i || line_rd_i)) begin
                base  <= line_addr_i[LINE_ADDR_W-1:5];
                beats <= 2'd0;
                if (line_we_i) begin
                    wbuf <= line_data_i;
                end
            end
            if (capture) begin
                if (beats[0]) begin
                    line_data_o[LINE_W-1:APP_DATA_W] <= app_rd_data;
                end else begin
                    line_data_o[APP_DATA_W-1:0] <= app_rd_data;
                end
                beats <= beats + 2'd1;
            end
        end
    end

    // MIG-side outputs are a pure decode of the state register and latched operands.
    always_comb begin
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_addr     = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_wdf_mask = '0;
        app_wdf_data = '0;
        case (state)
            ST_WD0: begin
                app_wdf_wren = 1'b1;
                app_wdf_end  = 1'b1;
                app_wdf_data = wbuf[APP_DATA_W-1:0];
            end
            ST_WD1: begin
                app_wdf_wren = 1'b1;
                app_wdf_end  = 1'b1;
                app_wdf_data = wbuf[LINE_W-1:APP_DATA_W];
            end
            ST_WC0: begin
                app_en   = 1'b1;
                app_cmd  = CMD_WRITE;
                app_addr = {base, 1'b0, 3'b000};
            end
            ST_WC1: begin
                app_en   = 1'b1;
                app_cmd  = CMD_WRITE;
                app_addr = {base, 1'b1, 3'b000};
            end
            ST_RC0: begin
                app_en   = 1'b1;
                app_cmd  = CMD_READ;
                app_addr = {base, 1'b0, 3'b000};
            end
            ST_RC1: begin
                app_en   = 1'b1;
                app_cmd  = CMD_READ;
                app_addr = {base, 1'b1, 3'b000};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ddr3_line_adapter.sv
// Randomised bench for ddr3_line_adapter: transaction-level scoreboard of MIG commands,
// write beats and returned lines, plus a latency-randomising MIG read responder.
module tb_ddr3_line_adapter;
    import ddr3_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [28:0]  line_addr_i = '0;
    logic [255:0] line_data_i = '0;
    logic [255:0] line_data_o;
    logic         line_we_i = 1'b0;
    logic         line_rd_i = 1'b0;
    logic         line_ack_o;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy = 1'b1;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy = 1'b1;
    logic [127:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0;
    logic         init_calib_complete = 1'b0;
    logic [3:0]   state_o;

    ddr3_line_adapter dut (
        .clk(clk), .rst(rst),
        .line_addr_i(line_addr_i), .line_data_i(line_data_i), .line_data_o(line_data_o),
        .line_we_i(line_we_i), .line_rd_i(line_rd_i), .line_ack_o(line_ack_o),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .init_calib_complete(init_calib_complete), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_count = 0;
    int exp_acks = 0;
    int beats_sent = 0;
    int last_due = 0;
    bit rand_rdy = 1'b0;
    logic [255:0] last_line = '0;

    logic [30:0]  exp_cmd[$];
    logic [127:0] exp_wdf[$];
    logic [30:0]  obs_cmd[$];
    logic [127:0] obs_wdf[$];
    int           rsp_due[$];
    logic [127:0] rsp_data[$];
    int           lat_plan[$];
    logic [127:0] data_plan[$];

    logic        cmd_stall = 1'b0;
    logic        wdf_stall = 1'b0;
    logic [30:0] held_cmd;
    logic [127:0] held_wdf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic logic [127:0] mem_word(input logic [27:0] a);
        logic [31:0] h;
        h = ({4'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        return {h, ~h, h ^ 32'hFFFF_0000, {4'h0, a}};
    endfunction

    // Scoreboard: every handshake must match the next expected command or beat,
    // and a stalled request must be re-presented unchanged.
    always @(negedge clk) begin
        int lat;
        int due;
        if (line_ack_o) ack_count++;
        if (rst) begin
            cmd_stall = 1'b0;
            wdf_stall = 1'b0;
        end else begin
            if (cmd_stall) checkOutput("cmd_hold", {app_en, app_cmd, app_addr}, {1'b1, held_cmd});
            if (wdf_stall) checkOutput("wdf_hold", {app_wdf_wren, app_wdf_data}, {1'b1, held_wdf});
            cmd_stall = 1'b0;
            wdf_stall = 1'b0;
            if (app_en) begin
                if (app_rdy) begin
                    obs_cmd.push_back({app_cmd, app_addr});
                    if (exp_cmd.size() == 0) failNow("cmd_unexpected");
                    else checkOutput("cmd", {app_cmd, app_addr}, exp_cmd.pop_front());
                    if (app_cmd == CMD_READ) begin
                        lat = (lat_plan.size() != 0) ? lat_plan.pop_front() : int'($urandom_range(1, 8));
                        due = cyc + 1 + lat;
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        rsp_due.push_back(due);
                        rsp_data.push_back((data_plan.size() != 0) ? data_plan.pop_front() : mem_word(app_addr));
                    end
                end else begin
                    cmd_stall = 1'b1;
                    held_cmd = {app_cmd, app_addr};
                end
            end
            if (app_wdf_wren) begin
                if (app_wdf_rdy) begin
                    obs_wdf.push_back(app_wdf_data);
                    if (exp_wdf.size() == 0) failNow("wdf_unexpected");
                    else checkOutput("wdf", {app_wdf_end, app_wdf_mask, app_wdf_data}, {1'b1, 16'h0, exp_wdf.pop_front()});
                end else begin
                    wdf_stall = 1'b1;
                    held_wdf = app_wdf_data;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            app_rdy     = 1'($urandom_range(0, 1));
            app_wdf_rdy = 1'($urandom_range(0, 1));
        end else begin
            app_rdy     = 1'b1;
            app_wdf_rdy = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if ((rsp_due.size() != 0) && (rsp_due[0] <= cyc)) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = rsp_data.pop_front();
            void'(rsp_due.pop_front());
            beats_sent++;
        end else begin
            app_rd_data_valid = 1'b0;
            app_rd_data = {4{$urandom}};
        end
    end

    task automatic applyStimulus(input logic we, input logic rd, input logic [28:0] addr, input logic [255:0] data);
        line_we_i   = we;
        line_rd_i   = rd;
        line_addr_i = addr;
        line_data_i = data;
    endtask

    task automatic waitAck(output int cycles);
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (line_ack_o) return;
            cycles++;
        end
        failNow("ack_timeout");
    endtask

    // Issues one line request in the cycle after the call and checks the line at its ack.
    task automatic runTxn(input logic we, input logic rd, input logic [28:0] addr,
                          input logic [255:0] data, output int lat);
        logic [23:0]  b;
        logic [255:0] model_line;
        b = addr[28:5];
        if (we) begin
            exp_wdf.push_back(data[127:0]);
            exp_wdf.push_back(data[255:128]);
            exp_cmd.push_back({CMD_WRITE, b, 4'h0});
            exp_cmd.push_back({CMD_WRITE, b, 4'h8});
        end else begin
            exp_cmd.push_back({CMD_READ, b, 4'h0});
            exp_cmd.push_back({CMD_READ, b, 4'h8});
            if (data_plan.size() >= 2) model_line = {data_plan[1], data_plan[0]};
            else model_line = {mem_word({b, 4'h8}), mem_word({b, 4'h0})};
        end
        @(posedge clk);
        #1;
        applyStimulus(we, rd, addr, data);
        exp_acks++;
        waitAck(lat);
        if (we) begin
            checkOutput("line_hold", line_data_o, last_line);
        end else begin
            checkOutput("read_line", line_data_o, model_line);
            last_line = model_line;
        end
    endtask

    task automatic bootCheck();
        @(posedge clk);
        #1;
        init_calib_complete = 1'b1;
        exp_acks++;
        @(negedge clk);
        checkOutput("boot_ack_before", line_ack_o, 1'b0);
        @(negedge clk);
        checkOutput("boot_ack_pulse", line_ack_o, 1'b1);
        @(negedge clk);
        checkOutput("boot_ack_after", line_ack_o, 1'b0);
    endtask

    initial begin
        int lat;
        int gap;
        logic [255:0] line;
        logic we;
        logic rd;
        bit reached;

        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {line_ack_o, app_en, app_wdf_wren, app_wdf_end, app_cmd,
                                   app_wdf_mask, app_addr, state_o}, '0);
        checkOutput("reset_wdf_data", app_wdf_data, '0);
        checkOutput("reset_line_data", line_data_o, '0);

        // Calibration phase: a held read request must be ignored.
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 29'h0000_0100, '0);
        repeat (20) @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("calib_ack_count", ack_count, 0);
        bootCheck();

        // Directed write then an immediate read of the neighbouring line (eviction pattern).
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'hDEAD_0000 + 32'(i);
        obs_cmd.delete();
        obs_wdf.delete();
        runTxn(1'b1, 1'b0, 29'h0000_01F0, line, lat);
        checkOutput("write_latency", lat, 5);
        checkOutput("wdf_beat_lo", obs_wdf[0], 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000);
        checkOutput("wdf_beat_hi", obs_wdf[1], 128'hDEAD0007_DEAD0006_DEAD0005_DEAD0004);
        checkOutput("wr_cmd0", obs_cmd[0], {3'b000, 28'h00000F0});
        checkOutput("wr_cmd1", obs_cmd[1], {3'b000, 28'h00000F8});

        lat_plan.push_back(1);
        lat_plan.push_back(7);
        data_plan.push_back({4{32'hAAAA_5555}});
        data_plan.push_back({4{32'hBBBB_6666}});
        runTxn(1'b0, 1'b1, 29'h0000_01F4, '0, lat);
        checkOutput("read_literal", line_data_o, {{4{32'hBBBB_6666}}, {4{32'hAAAA_5555}}});
        checkOutput("eviction_cmd_count", obs_cmd.size(), 4);
        checkOutput("rd_cmd0", obs_cmd[2], {3'b001, 28'h00000F0});
        checkOutput("rd_cmd1", obs_cmd[3], {3'b001, 28'h00000F8});

        // Random traffic with randomly stalling MIG ready signals.
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            rd = we ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
            runTxn(we, rd, 29'($urandom), line, lat);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                @(posedge clk);
                #1;
                applyStimulus(1'b0, 1'b0, '0, '0);
                repeat (gap - 1) @(posedge clk);
            end
        end

        // Reset in RWAIT after one beat; the late second beat lands during calibration.
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        beats_sent = 0;
        lat_plan.push_back(1);
        lat_plan.push_back(12);
        exp_cmd.push_back({CMD_READ, 24'h000123, 4'h0});
        exp_cmd.push_back({CMD_READ, 24'h000123, 4'h8});
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, {24'h000123, 5'h00}, '0);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((beats_sent == 1) && (state_o == ST_RWAIT)) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) failNow("rwait_not_reached");
        @(posedge clk);
        #1;
        rst = 1'b1;
        init_calib_complete = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_line = '0;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (beats_sent == 2) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) failNow("stale_beat_missing");
        repeat (2) @(negedge clk);
        checkOutput("stale_line_data", line_data_o, '0);
        checkOutput("stale_state", state_o, ST_CALIB);
        bootCheck();
        runTxn(1'b0, 1'b1, 29'h0ABC_DE00, '0, lat);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);

        checkOutput("cmd_queue_empty", exp_cmd.size(), 0);
        checkOutput("wdf_queue_empty", exp_wdf.size(), 0);
        checkOutput("ack_total", ack_count, exp_acks);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
